// File: rtl/snake_pkg.sv
// Shared types, defaults and helpers for the snake game engine.
package snake_pkg;

  localparam int COORD_W      = 6;
  localparam int LEN_W        = 7;
  localparam int GRID_W_DEF   = 64;
  localparam int GRID_H_DEF   = 48;
  localparam int MAX_LEN_DEF  = 64;
  localparam int INIT_LEN_DEF = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CALC   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

  function automatic logic [COORD_W-1:0] wrap_step(input logic [COORD_W-1:0] c,
                                                   input logic               dec,
                                                   input logic [COORD_W-1:0] c_max);
    if (dec) return (c == {COORD_W{1'b0}}) ? c_max : c - COORD_W'(1);
    else     return (c == c_max) ? {COORD_W{1'b0}} : c + COORD_W'(1);
  endfunction

  function automatic cell_t next_cell(input cell_t              h,
                                      input dir_e               d,
                                      input logic [COORD_W-1:0] x_max,
                                      input logic [COORD_W-1:0] y_max);
    cell_t n;
    n = h;
    case (d)
      DIR_UP:    n.y = wrap_step(h.y, 1'b1, y_max);
      DIR_DOWN:  n.y = wrap_step(h.y, 1'b0, y_max);
      DIR_LEFT:  n.x = wrap_step(h.x, 1'b1, x_max);
      DIR_RIGHT: n.x = wrap_step(h.x, 1'b0, x_max);
      default:   n = h;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Move-control and pixel-query bus of the snake engine.
interface snake_engine_if;
  logic                             iTick;
  logic [1:0]                       iDir;
  logic                             iGrow;
  logic                             iQuery_Valid;
  logic [snake_pkg::COORD_W-1:0]    iQuery_X;
  logic [snake_pkg::COORD_W-1:0]    iQuery_Y;
  logic                             oHit_Valid;
  logic                             oHit;
  logic [snake_pkg::COORD_W-1:0]    oHead_X;
  logic [snake_pkg::COORD_W-1:0]    oHead_Y;
  logic [snake_pkg::LEN_W-1:0]      oLength;
  logic                             oBusy;
  logic                             oCollide;

  modport slave (
    input  iTick, iDir, iGrow, iQuery_Valid, iQuery_X, iQuery_Y,
    output oHit_Valid, oHit, oHead_X, oHead_Y, oLength, oBusy, oCollide
  );

  modport master (
    output iTick, iDir, iGrow, iQuery_Valid, iQuery_X, iQuery_Y,
    input  oHit_Valid, oHit, oHead_X, oHead_Y, oLength, oBusy, oCollide
  );
endinterface

// File: rtl/snake_occupancy_map.sv
// Grid occupancy bitmap: registered pixel query port plus a probe/set/clear
// port used by the move FSM.
module snake_occupancy_map
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iQuery_Valid,
  input  logic [COORD_W-1:0] iQuery_X,
  input  logic [COORD_W-1:0] iQuery_Y,
  output logic               oHit_Valid,
  output logic               oHit,
  input  cell_t              i_probe,
  output logic               o_probe_hit,
  input  logic               i_set_en,
  input  cell_t              i_set_cell,
  input  logic               i_clr_en,
  input  cell_t              i_clr_cell
);

  localparam int                  HEAD0_X  = GRID_W / 2;
  localparam int                  HEAD0_Y  = GRID_H / 2;
  localparam logic [GRID_W-1:0]   ROW_ONES = '1;
  localparam logic [GRID_W-1:0]   INIT_ROW = (ROW_ONES >> (GRID_W - INIT_LEN)) << HEAD0_X;
  localparam logic [COORD_W:0]    X_LIM    = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]    Y_LIM    = (COORD_W+1)'(GRID_H);

  logic [GRID_W-1:0] r_map [GRID_H];
  logic              r_hit;
  logic              r_hit_valid;
  logic              w_q_in_range;
  logic              w_q_bit;

  assign w_q_in_range = ({1'b0, iQuery_X} < X_LIM) && ({1'b0, iQuery_Y} < Y_LIM);
  assign w_q_bit      = w_q_in_range ? r_map[iQuery_Y][iQuery_X] : 1'b0;
  assign o_probe_hit  = r_map[i_probe.y][i_probe.x];
  assign oHit         = r_hit;
  assign oHit_Valid   = r_hit_valid;

  // Storage; clear precedes set so a head stepping onto the vacating tail stays occupied.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int r = 0; r < GRID_H; r++) r_map[r] <= (r == HEAD0_Y) ? INIT_ROW : '0;
    end else begin
      if (i_clr_en) r_map[i_clr_cell.y][i_clr_cell.x] <= 1'b0;
      if (i_set_en) r_map[i_set_cell.y][i_set_cell.x] <= 1'b1;
    end
  end

  // Query port samples the pre-update bitmap, giving read-before-write.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hit       <= 1'b0;
      r_hit_valid <= 1'b0;
    end else begin
      r_hit       <= iQuery_Valid & w_q_bit;
      r_hit_valid <= iQuery_Valid;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body tracker: ring of body cells, occupancy bitmap and a
// tick-driven IDLE/CALC/CHECK/COMMIT/HALT move sequencer.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = MAX_LEN_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF
) (
  input logic           iCLK,
  input logic           iRST_N,
  snake_engine_if.slave bus
);

  localparam int                 PTR_W    = $clog2(MAX_LEN);
  localparam int                 HEAD0_X  = GRID_W / 2;
  localparam int                 HEAD0_Y  = GRID_H / 2;
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_INIT = LEN_W'(INIT_LEN);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  dir_e             r_cur_dir;
  dir_e             r_req_dir;
  dir_e             w_eff_dir;
  logic             r_grow;
  logic             r_collide_pend;
  logic             r_collide;
  logic             r_busy;
  cell_t            r_head;
  cell_t            r_next;
  cell_t            r_tail;
  cell_t            w_next_head;
  cell_t            w_tail;
  cell_t            r_ring [MAX_LEN];
  logic [PTR_W-1:0] r_head_ptr;
  logic [PTR_W-1:0] w_tail_ptr;
  logic [LEN_W-1:0] r_len;
  logic             w_probe_hit;
  logic             w_grow_taken;
  logic             w_collide;
  logic             w_commit;

  assign w_tail_ptr   = r_head_ptr + PTR_W'(r_len - LEN_W'(1));
  assign w_tail       = r_ring[w_tail_ptr];
  assign w_eff_dir    = (r_req_dir == opposite(r_cur_dir)) ? r_cur_dir : r_req_dir;
  assign w_next_head  = next_cell(r_head, w_eff_dir, X_MAX, Y_MAX);
  assign w_grow_taken = r_grow && (r_len < LEN_MAX);
  // Moving onto the tail is legal when the tail is about to vacate.
  assign w_collide    = w_probe_hit && !((r_next == r_tail) && !w_grow_taken);
  assign w_commit     = (r_state == ST_COMMIT) && !r_collide_pend;

  // Next-state decode for the move sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.iTick && !r_collide) w_state_nxt = ST_CALC; else w_state_nxt = ST_IDLE;
      ST_CALC:   w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = ST_COMMIT;
      ST_COMMIT: if (r_collide_pend) w_state_nxt = ST_HALT; else w_state_nxt = ST_IDLE;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state, move pipeline registers and head/length bookkeeping.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_cur_dir      <= DIR_LEFT;
      r_req_dir      <= DIR_LEFT;
      r_grow         <= 1'b0;
      r_next         <= '0;
      r_tail         <= '0;
      r_collide_pend <= 1'b0;
      r_collide      <= 1'b0;
      r_head         <= cell_t'({COORD_W'(HEAD0_X), COORD_W'(HEAD0_Y)});
      r_head_ptr     <= '0;
      r_len          <= LEN_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_COMMIT);
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_CALC)) begin
        r_req_dir <= dir_e'(bus.iDir);
        r_grow    <= bus.iGrow;
      end
      if (r_state == ST_CALC) begin
        r_cur_dir <= w_eff_dir;
        r_next    <= w_next_head;
        r_tail    <= w_tail;
      end
      if (r_state == ST_CHECK) r_collide_pend <= w_collide;
      if ((r_state == ST_COMMIT) && r_collide_pend) r_collide <= 1'b1;
      if (w_commit) begin
        r_head     <= r_next;
        r_head_ptr <= r_head_ptr - PTR_W'(1);
        if (w_grow_taken) r_len <= r_len + LEN_W'(1);
      end
    end
  end

  // Body ring, head first; a new head lands just below the current head pointer.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < MAX_LEN; i++)
        r_ring[i] <= (i < INIT_LEN) ? cell_t'({COORD_W'(HEAD0_X + i), COORD_W'(HEAD0_Y)}) : '0;
    end else begin
      if (w_commit) r_ring[r_head_ptr - PTR_W'(1)] <= r_next;
    end
  end

  snake_occupancy_map #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .INIT_LEN (INIT_LEN)
  ) u_map (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iQuery_Valid (bus.iQuery_Valid),
    .iQuery_X     (bus.iQuery_X),
    .iQuery_Y     (bus.iQuery_Y),
    .oHit_Valid   (bus.oHit_Valid),
    .oHit         (bus.oHit),
    .i_probe      (r_next),
    .o_probe_hit  (w_probe_hit),
    .i_set_en     (w_commit),
    .i_set_cell   (r_next),
    .i_clr_en     (w_commit && !w_grow_taken),
    .i_clr_cell   (r_tail)
  );

  assign bus.oHead_X  = r_head.x;
  assign bus.oHead_Y  = r_head.y;
  assign bus.oLength  = r_len;
  assign bus.oBusy    = r_busy;
  assign bus.oCollide = r_collide;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine against a queue-based snake model.
module tb_snake_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  snake_engine_if bus();

  snake_engine u_dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } pt_t;

  pt_t m_body[$];
  int  m_dir;
  bit  m_coll;

  function automatic bit m_occ(int x, int y);
    foreach (m_body[i]) if (m_body[i].x == x && m_body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_body.delete();
    for (int i = 0; i < 4; i++) m_body.push_back('{x: 32 + i, y: 24});
    m_dir  = 2;
    m_coll = 1'b0;
  endtask

  // One move of the game rules: step, wrap, tail vacates unless growing.
  task automatic m_move(int d, bit g);
    pt_t nh;
    pt_t rest[$];
    bit  taken;
    bit  hit;
    if (m_coll) return;
    if (d == (m_dir ^ 1)) d = m_dir;
    m_dir = d;
    nh = m_body[0];
    case (d)
      0:       nh.y = (nh.y + 47) % 48;
      1:       nh.y = (nh.y + 1) % 48;
      2:       nh.x = (nh.x + 63) % 64;
      default: nh.x = (nh.x + 1) % 64;
    endcase
    taken = g && (m_body.size() < 64);
    rest = m_body;
    if (!taken) void'(rest.pop_back());
    hit = 1'b0;
    foreach (rest[i]) if (rest[i].x == nh.x && rest[i].y == nh.y) hit = 1'b1;
    if (hit) m_coll = 1'b1;
    else begin
      rest.push_front(nh);
      m_body = rest;
    end
  endtask

  task automatic move(int d, bit g);
    @(negedge clk);
    bus.iTick = 1'b1;
    bus.iDir  = 2'(d);
    bus.iGrow = g;
    @(negedge clk);
    bus.iTick = 1'b0;
    bus.iGrow = 1'b0;
    m_move(d, g);
    repeat (3) @(negedge clk);
  endtask

  task automatic query(int x, int y, output bit h, output bit v);
    @(negedge clk);
    bus.iQuery_Valid = 1'b1;
    bus.iQuery_X     = 6'(x);
    bus.iQuery_Y     = 6'(y);
    @(negedge clk);
    bus.iQuery_Valid = 1'b0;
    h = bus.oHit;
    v = bus.oHit_Valid;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.iTick = 1'b0;
    bus.iGrow = 1'b0;
    bus.iQuery_Valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    bit h, v;
    move(2, 0);
    @(negedge clk);
    bus.iQuery_Valid = 1'b1;
    bus.iQuery_X = 6'd34;
    bus.iQuery_Y = 6'd24;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd32, 6'd24}) begin n_fail++; $display("FAIL reset_head: got (%0d,%0d) want (32,24)", bus.oHead_X, bus.oHead_Y); end
    n_tests++; if (bus.oLength !== 7'd4) begin n_fail++; $display("FAIL reset_len: got %0d want 4", bus.oLength); end
    n_tests++; if (bus.oCollide !== 1'b0 || bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got coll=%0b busy=%0b want 0 0", bus.oCollide, bus.oBusy); end
    n_tests++; if (bus.oHit !== 1'b0 || bus.oHit_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got hit=%0b valid=%0b want 0 0", bus.oHit, bus.oHit_Valid); end
    bus.iQuery_Valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    query(35, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL reset_body_tail: got %0b want 1", h); end
    query(31, 24, h, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL reset_clear: got %0b want 0", h); end
  endtask

  task automatic test_basic_left();
    bit h, v;
    do_reset();
    @(negedge clk);
    bus.iTick = 1'b1;
    bus.iDir  = 2'b10;
    @(negedge clk);
    bus.iTick = 1'b0;
    n_tests++; if (bus.oBusy !== 1'b1) begin n_fail++; $display("FAIL busy_calc: got %0b want 1", bus.oBusy); end
    repeat (2) @(negedge clk);
    n_tests++; if (bus.oHead_X !== 6'd32 || bus.oBusy !== 1'b1) begin n_fail++; $display("FAIL early_head: got x=%0d busy=%0b want 32 1", bus.oHead_X, bus.oBusy); end
    @(negedge clk);
    m_move(2, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd31, 6'd24}) begin n_fail++; $display("FAIL left_head: got (%0d,%0d) want (31,24)", bus.oHead_X, bus.oHead_Y); end
    n_tests++; if (bus.oBusy !== 1'b0 || bus.oLength !== 7'd4) begin n_fail++; $display("FAIL left_done: got busy=%0b len=%0d want 0 4", bus.oBusy, bus.oLength); end
    query(35, 24, h, v);
    n_tests++; if (h !== 1'b0 || v !== 1'b1) begin n_fail++; $display("FAIL old_tail: got hit=%0b valid=%0b want 0 1", h, v); end
    query(34, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL body_cell: got %0b want 1", h); end
    query(10, 48, h, v);
    n_tests++; if (h !== 1'b0 || v !== 1'b1) begin n_fail++; $display("FAIL out_of_range: got hit=%0b valid=%0b want 0 1", h, v); end
    @(negedge clk);
    n_tests++; if (bus.oHit_Valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %0b want 0", bus.oHit_Valid); end
  endtask

  task automatic test_reversal();
    do_reset();
    move(3, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd31, 6'd24}) begin n_fail++; $display("FAIL reversal: got (%0d,%0d) want (31,24)", bus.oHead_X, bus.oHead_Y); end
    move(3, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd30, 6'd24}) begin n_fail++; $display("FAIL reversal_again: got (%0d,%0d) want (30,24)", bus.oHead_X, bus.oHead_Y); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (32) move(2, 0);
    n_tests++; if (bus.oHead_X !== 6'd0) begin n_fail++; $display("FAIL reach_x0: got %0d want 0", bus.oHead_X); end
    move(2, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd63, 6'd24}) begin n_fail++; $display("FAIL wrap_left: got (%0d,%0d) want (63,24)", bus.oHead_X, bus.oHead_Y); end
    repeat (23) move(1, 0);
    n_tests++; if (bus.oHead_Y !== 6'd47) begin n_fail++; $display("FAIL reach_y47: got %0d want 47", bus.oHead_Y); end
    move(1, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd63, 6'd0}) begin n_fail++; $display("FAIL wrap_down: got (%0d,%0d) want (63,0)", bus.oHead_X, bus.oHead_Y); end
    move(2, 0);
    move(0, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd62, 6'd47}) begin n_fail++; $display("FAIL wrap_up: got (%0d,%0d) want (62,47)", bus.oHead_X, bus.oHead_Y); end
    move(3, 0);
    move(3, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd0, 6'd47}) begin n_fail++; $display("FAIL wrap_right: got (%0d,%0d) want (0,47)", bus.oHead_X, bus.oHead_Y); end
  endtask

  task automatic test_grow();
    bit h, v;
    int qx;
    do_reset();
    move(2, 1);
    n_tests++; if (bus.oLength !== 7'd5) begin n_fail++; $display("FAIL grow_len: got %0d want 5", bus.oLength); end
    query(35, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL grow_tail_kept: got %0b want 1", h); end
    for (int i = 0; i < 62; i++) begin
      move(2, 1);
      n_tests++; if (bus.oLength !== 7'(m_body.size()) || bus.oCollide !== m_coll) begin n_fail++; $display("FAIL grow_step%0d: got len=%0d coll=%0b want %0d %0b", i, bus.oLength, bus.oCollide, m_body.size(), m_coll); end
    end
    n_tests++; if (bus.oLength !== 7'd64 || bus.oCollide !== 1'b0) begin n_fail++; $display("FAIL grow_cap: got len=%0d coll=%0b want 64 0", bus.oLength, bus.oCollide); end
    for (int i = 0; i < 6; i++) begin
      qx = $urandom_range(0, 63);
      query(qx, 24 - (i % 2), h, v);
      n_tests++; if (h !== m_occ(qx, 24 - (i % 2))) begin n_fail++; $display("FAIL full_row_q(%0d): got %0b want %0b", qx, h, m_occ(qx, 24 - (i % 2))); end
    end
  endtask

  task automatic test_collision();
    bit h, v;
    do_reset();
    move(2, 1);
    move(0, 0);
    move(3, 0);
    move(1, 0);
    n_tests++; if (bus.oCollide !== 1'b1) begin n_fail++; $display("FAIL collide_flag: got %0b want 1", bus.oCollide); end
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd32, 6'd23} || bus.oLength !== 7'd5) begin n_fail++; $display("FAIL collide_hold: got (%0d,%0d) len=%0d want (32,23) 5", bus.oHead_X, bus.oHead_Y, bus.oLength); end
    move(2, 0);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd32, 6'd23} || bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL halt_ignore: got (%0d,%0d) busy=%0b want (32,23) 0", bus.oHead_X, bus.oHead_Y, bus.oBusy); end
    query(32, 24, h, v);
    n_tests++; if (h !== 1'b1 || v !== 1'b1) begin n_fail++; $display("FAIL halt_query: got hit=%0b valid=%0b want 1 1", h, v); end
    do_reset();
    move(0, 0);
    move(3, 0);
    move(1, 0);
    n_tests++; if (bus.oCollide !== 1'b0 || {bus.oHead_X, bus.oHead_Y} !== {6'd33, 6'd24}) begin n_fail++; $display("FAIL tail_chase: got coll=%0b (%0d,%0d) want 0 (33,24)", bus.oCollide, bus.oHead_X, bus.oHead_Y); end
    query(33, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL tail_chase_occ: got %0b want 1", h); end
    query(34, 24, h, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL tail_chase_vac: got %0b want 0", h); end
  endtask

  task automatic test_back_to_back();
    bit h, v;
    do_reset();
    @(negedge clk);
    bus.iTick = 1'b1;
    bus.iDir  = 2'b10;
    repeat (3) @(negedge clk);
    bus.iQuery_Valid = 1'b1;
    bus.iQuery_X = 6'd31;
    bus.iQuery_Y = 6'd24;
    @(negedge clk);
    bus.iTick = 1'b0;
    bus.iQuery_Valid = 1'b0;
    m_move(2, 0);
    n_tests++; if (bus.oHit !== 1'b0 || bus.oHit_Valid !== 1'b1) begin n_fail++; $display("FAIL commit_query: got hit=%0b valid=%0b want 0 1", bus.oHit, bus.oHit_Valid); end
    repeat (6) @(negedge clk);
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd31, 6'd24} || bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL single_move: got (%0d,%0d) busy=%0b want (31,24) 0", bus.oHead_X, bus.oHead_Y, bus.oBusy); end
    query(31, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL post_commit_query: got %0b want 1", h); end
  endtask

  task automatic test_reset_mid();
    bit h, v;
    do_reset();
    @(negedge clk);
    bus.iTick = 1'b1;
    bus.iDir  = 2'b00;
    @(negedge clk);
    bus.iTick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'd32, 6'd24} || bus.oLength !== 7'd4) begin n_fail++; $display("FAIL abort_head: got (%0d,%0d) len=%0d want (32,24) 4", bus.oHead_X, bus.oHead_Y, bus.oLength); end
    query(32, 23, h, v);
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL abort_newcell: got %0b want 0", h); end
    query(35, 24, h, v);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL abort_tail: got %0b want 1", h); end
    move(2, 0);
    move(2, 0);
    query(34, 24, h, v);
    n_tests++; if (h !== 1'b0 || bus.oHead_X !== 6'd30) begin n_fail++; $display("FAIL abort_resume: got hit=%0b x=%0d want 0 30", h, bus.oHead_X); end
  endtask

  task automatic test_random();
    int d, qx, qy, k;
    bit g, h, v;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      d = $urandom_range(0, 3);
      g = ($urandom_range(0, 3) == 0);
      move(d, g);
      n_tests++; if ({bus.oHead_X, bus.oHead_Y} !== {6'(m_body[0].x), 6'(m_body[0].y)} || bus.oLength !== 7'(m_body.size()) || bus.oCollide !== m_coll) begin
        n_fail++; $display("FAIL rand_move%0d: got (%0d,%0d) len=%0d coll=%0b want (%0d,%0d) %0d %0b", i, bus.oHead_X, bus.oHead_Y, bus.oLength, bus.oCollide, m_body[0].x, m_body[0].y, m_body.size(), m_coll);
      end
      if ($urandom_range(0, 1) == 1) begin
        k  = $urandom_range(0, m_body.size() - 1);
        qx = m_body[k].x;
        qy = m_body[k].y;
      end else begin
        qx = $urandom_range(0, 63);
        qy = $urandom_range(0, 51);
      end
      query(qx, qy, h, v);
      n_tests++; if (h !== m_occ(qx, qy) || v !== 1'b1) begin n_fail++; $display("FAIL rand_query(%0d,%0d): got hit=%0b valid=%0b want %0b 1", qx, qy, h, v, m_occ(qx, qy)); end
      if (m_coll) do_reset();
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.iTick        = 1'b0;
    bus.iDir         = 2'b10;
    bus.iGrow        = 1'b0;
    bus.iQuery_Valid = 1'b0;
    bus.iQuery_X     = 6'd0;
    bus.iQuery_Y     = 6'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    test_reset();
    test_basic_left();
    test_reversal();
    test_wrap();
    test_grow();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
